decode_cycle: RTL

// - Second pipeline stage, directly downstream of the fetch stage: consumes InstrD/PCD/PCPlus4D.
// - Decodes the RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
// - Holds the 32-entry register file, written back from the W stage.
// - Generates control signals and the sign-extended immediate.
// - Registers everything into the ID/EX pipeline register that feeds the execute stage.

---
 rtl/decode_cycle.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// Decode stage: RV32I subset decoder, 32-entry register file and ID/EX pipeline register.
// Define WB_BYPASS_EN to forward the writeback value to same-cycle register reads.
module decode_cycle #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [ADDR_W-1:0] PCD,
  input  logic [ADDR_W-1:0] PCPlus4D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [4:0]        RDW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic              IllegalE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [4:0]        RS1E,
  output logic [4:0]        RS2E,
  output logic [4:0]        RDE,
  output logic [ADDR_W-1:0] PCE,
  output logic [ADDR_W-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];
  assign rd     = InstrD[11:7];

  // Register file; entry 0 is a constant so x0 never holds anything but zero.
  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        always_ff @(posedge clk) begin
          if (!rst) begin
            regs[gi] <= '0;
          end else if (RegWriteW && (RDW == 5'(gi))) begin
            regs[gi] <= ResultW;
          end
        end
      end
    end
  endgenerate

  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

`ifdef WB_BYPASS_EN
  logic wb_live;
  assign wb_live  = RegWriteW && (RDW != 5'd0);
  assign rd1_next = (wb_live && (RDW == rs1)) ? ResultW : regs[rs1];
  assign rd2_next = (wb_live && (RDW == rs2)) ? ResultW : regs[rs2];
`else
  assign rd1_next = regs[rs1];
  assign rd2_next = regs[rs2];
`endif

  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_j;

  assign imm_i = {{(DATA_W-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(DATA_W-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(DATA_W-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                  InstrD[11:8], 1'b0};
  assign imm_j = {{(DATA_W-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                  InstrD[30:21], 1'b0};

  logic              reg_write_next;
  logic              mem_write_next;
  logic              jump_next;
  logic              branch_next;
  logic              alu_src_next;
  logic              illegal_next;
  logic [1:0]        result_src_next;
  logic [2:0]        alu_control_next;
  logic [DATA_W-1:0] imm_next;
  logic              alu_ok;
  logic [2:0]        alu_op;

  // Shared by R and I-ALU; sub only exists as an R-type with funct7[5] set.
  always_comb begin
    alu_ok = 1'b1;
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (opcode == OP_R && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_ok = 1'b0;
    endcase
    if (opcode == OP_R && funct7 != 7'b0000000 &&
        !(funct7 == 7'b0100000 && funct3 == 3'b000)) begin
      alu_ok = 1'b0;
    end
  end

  always_comb begin
    reg_write_next   = 1'b0;
    mem_write_next   = 1'b0;
    jump_next        = 1'b0;
    branch_next      = 1'b0;
    alu_src_next     = 1'b0;
    illegal_next     = 1'b0;
    result_src_next  = 2'b00;
    alu_control_next = ALU_ADD;
    imm_next         = '0;
    case (opcode)
      OP_LW: begin
        if (funct3 == 3'b010) begin
          reg_write_next  = 1'b1;
          alu_src_next    = 1'b1;
          result_src_next = 2'b01;
          imm_next        = imm_i;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OP_SW: begin
        if (funct3 == 3'b010) begin
          mem_write_next = 1'b1;
          alu_src_next   = 1'b1;
          imm_next       = imm_s;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OP_R, OP_I: begin
        if (alu_ok) begin
          reg_write_next   = 1'b1;
          alu_src_next     = (opcode == OP_I);
          alu_control_next = alu_op;
          imm_next         = (opcode == OP_I) ? imm_i : '0;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OP_BEQ: begin
        if (funct3 == 3'b000) begin
          branch_next      = 1'b1;
          alu_control_next = ALU_SUB;
          imm_next         = imm_b;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OP_JAL: begin
        reg_write_next  = 1'b1;
        jump_next       = 1'b1;
        result_src_next = 2'b10;
        imm_next        = imm_j;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  // ID/EX register: reset and flush both load a bubble.
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      IllegalE    <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RS1E        <= 5'd0;
      RS2E        <= 5'd0;
      RDE         <= 5'd0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write_next;
      MemWriteE   <= mem_write_next;
      JumpE       <= jump_next;
      BranchE     <= branch_next;
      ALUSrcE     <= alu_src_next;
      IllegalE    <= illegal_next;
      ResultSrcE  <= result_src_next;
      ALUControlE <= alu_control_next;
      RD1E        <= rd1_next;
      RD2E        <= rd2_next;
      ImmExtE     <= imm_next;
      RS1E        <= rs1;
      RS2E        <= rs2;
      RDE         <= rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
